// File: rtl/rriot_io_timer.sv
// RRIOT-style I/O and interval timer: NUM_PORTS bidirectional ports with per-bit DDR,
// an edge-detect interrupt on port 0 MSB, and a prescaled down-counter with underflow flag.
module rriot_io_timer #(
  parameter int unsigned PORT_WIDTH  = 8,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned TIMER_WIDTH = 8,
  parameter int unsigned TIMER_BASE  = 8
) (
  input  logic                            phi2,
  input  logic                            rst,
  input  logic                            cs,
  input  logic                            we,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [PORT_WIDTH-1:0]           wdata,
  output logic [PORT_WIDTH-1:0]           rdata,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] pin_i,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pin_o,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] pin_oe,
  output logic                            irq
);

  localparam int unsigned W         = PORT_WIDTH;
  localparam int unsigned EDGE_ADDR = 2 * NUM_PORTS;
  localparam int unsigned FLAG_ADDR = 2 * NUM_PORTS + 1;
  localparam int unsigned PRE_W     = 10;

  logic [W-1:0]           port_o   [NUM_PORTS];
  logic [W-1:0]           port_ddr [NUM_PORTS];
  logic                   edge_en;
  logic                   edge_rise;
  logic                   edge_prev;
  logic                   edge_flag;
  logic [TIMER_WIDTH-1:0] count;
  logic [PRE_W-1:0]       pre;
  logic [1:0]             div_sel;
  logic                   timer_ien;
  logic                   timer_flag;
  logic                   fast;

  logic [31:0] a;
  logic        wr;
  logic        rd;
  logic        in_ports;
  logic        hit_edge;
  logic        hit_flag;
  logic        hit_timer;
  logic [2:0]  tk;
  logic        timer_wr;
  logic        timer_rd_clr;
  logic        flag_rd_clr;
  logic        edge_hit;
  logic        tick;
  logic        underflow;

  function automatic logic [PRE_W-1:0] reload(input logic [1:0] s);
    case (s)
      2'd0:    reload = 10'd0;
      2'd1:    reload = 10'd7;
      2'd2:    reload = 10'd63;
      default: reload = 10'd1023;
    endcase
  endfunction

  assign a            = 32'(addr);
  assign wr           = cs & we;
  assign rd           = cs & ~we;
  assign in_ports     = (a < EDGE_ADDR);
  assign hit_edge     = (a == EDGE_ADDR);
  assign hit_flag     = (a == FLAG_ADDR);
  assign hit_timer    = (a >= TIMER_BASE) && (a < TIMER_BASE + 8);
  assign tk           = a[2:0];
  assign timer_wr     = wr & hit_timer;
  assign timer_rd_clr = rd & hit_timer & ~tk[0];
  assign flag_rd_clr  = rd & (hit_flag | (hit_timer & tk[0]));

  assign edge_hit  = edge_en & (edge_rise ? (~edge_prev & pin_i[W-1])
                                          : (edge_prev & ~pin_i[W-1]));
  // After an underflow the prescaler is bypassed so the count steps every cycle.
  assign tick      = fast | (pre == '0);
  assign underflow = tick & (count == '0);

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        port_o[p]   <= '0;
        port_ddr[p] <= '0;
      end
    end else if (wr && in_ports) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if ((a >> 1) == p) begin
          if (a[0]) port_ddr[p] <= wdata;
          else      port_o[p]   <= wdata;
        end
      end
    end
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      edge_en   <= 1'b0;
      edge_rise <= 1'b0;
      edge_prev <= 1'b0;
      edge_flag <= 1'b0;
    end else begin
      edge_prev <= pin_i[W-1];
      if (wr && hit_edge) begin
        edge_en   <= wdata[1];
        edge_rise <= wdata[0];
      end
      if (edge_hit)         edge_flag <= 1'b1;
      else if (flag_rd_clr) edge_flag <= 1'b0;
    end
  end

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      count      <= '1;
      pre        <= reload(2'd3);
      div_sel    <= 2'd3;
      timer_ien  <= 1'b0;
      timer_flag <= 1'b0;
      fast       <= 1'b0;
    end else if (timer_wr) begin
      count      <= wdata[TIMER_WIDTH-1:0];
      pre        <= reload(tk[1:0]);
      div_sel    <= tk[1:0];
      timer_ien  <= tk[2];
      timer_flag <= 1'b0;
      fast       <= 1'b0;
    end else begin
      if (!fast) pre <= (pre == '0) ? reload(div_sel) : pre - PRE_W'(1);
      if (tick)  count <= count - TIMER_WIDTH'(1);
      if (underflow) begin
        timer_flag <= 1'b1;
        fast       <= 1'b1;
      end else if (timer_rd_clr) begin
        timer_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (in_ports) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if ((a >> 1) == p) begin
          rdata = a[0] ? port_ddr[p]
                       : (port_ddr[p] & port_o[p]) | (~port_ddr[p] & pin_i[p*W +: W]);
        end
      end
    end else if (hit_edge) begin
      rdata = W'({edge_en, edge_rise});
    end else if (hit_flag || (hit_timer && tk[0])) begin
      rdata[W-1] = timer_flag;
      rdata[W-2] = edge_flag;
    end else if (hit_timer) begin
      rdata = W'(count);
    end
  end

  always_comb begin
    pin_o  = '0;
    pin_oe = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      pin_o[p*W +: W]  = port_o[p];
      pin_oe[p*W +: W] = port_ddr[p];
    end
  end

  assign irq = (timer_flag & timer_ien) | (edge_flag & edge_en);

endmodule
